// File: rtl/adiabatic_pclk_gen_if.sv
// Control and rail-code bundle for the adiabatic power-clock sequencer.
//
// Handshake: start is a request that is accepted on any rising edge where the
// sequencer is idle (busy=0 and done=0); burst_len is captured on that same
// edge and ignored afterwards. stop is a level request sampled on every
// running edge and latched until the next period boundary. done is a
// one-cycle completion pulse; no acknowledgement is required.
interface adiabatic_pclk_gen_if #(
  parameter int DAC_W = 6,
  parameter int CNT_W = 16
);
  logic             start;
  logic [CNT_W-1:0] burst_len;
  logic             stop;
  logic             busy;
  logic             done;
  logic [DAC_W-1:0] clkpos1_code;
  logic [DAC_W-1:0] clkneg1_code;
  logic [DAC_W-1:0] clkpos2_code;
  logic [DAC_W-1:0] clkneg2_code;
  logic             sample_strobe;
  logic [CNT_W-1:0] period_count;

  modport master (
    output start, burst_len, stop,
    input  busy, done, clkpos1_code, clkneg1_code, clkpos2_code, clkneg2_code,
    input  sample_strobe, period_count
  );

  modport slave (
    input  start, burst_len, stop,
    output busy, done, clkpos1_code, clkneg1_code, clkpos2_code, clkneg2_code,
    output sample_strobe, period_count
  );
endinterface

// File: rtl/adiabatic_pclk_gen.sv
// Four-phase trapezoidal power-clock sequencer. Produces DAC ramp codes for
// two lagging rail pairs, a mid-HOLD sample strobe for second-stage outputs,
// and runs bursts of N periods or continuously until a graceful stop.
module adiabatic_pclk_gen #(
  parameter int QTR_CYCLES = 4,
  parameter int DAC_W      = 6,
  parameter int CNT_W      = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  adiabatic_pclk_gen_if.slave    bus,
  output logic [1:0]             dbg_state_o
);

  localparam logic [DAC_W-1:0] MAX    = {DAC_W{1'b1}};
  localparam int               STEP   = ((1 << DAC_W) - 1) / QTR_CYCLES;
  localparam int               QW     = (QTR_CYCLES > 2) ? $clog2(QTR_CYCLES) : 1;
  localparam logic [QW-1:0]    Q_LAST = QW'(QTR_CYCLES - 1);
  localparam logic [QW-1:0]    Q_MID  = QW'(QTR_CYCLES / 2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       ph_q, ph_d;
  logic [QW-1:0]    q_q, q_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stop_q, stop_d;
  logic             stop_now;

  logic [DAC_W-1:0] pos1_q, pos1_d, neg1_q, neg1_d;
  logic [DAC_W-1:0] pos2_q, pos2_d, neg2_q, neg2_d;
  logic             busy_q, busy_d, done_q, done_d, strobe_q, strobe_d;

  // Rising edge of the trapezoid; the last step is pinned to full scale so
  // a non-dividing QTR_CYCLES still reaches vdd.
  function automatic logic [DAC_W-1:0] ramp_code(input logic [QW-1:0] qv);
    logic [DAC_W-1:0] r;
    if (qv == Q_LAST) r = MAX;
    else              r = DAC_W'((int'(qv) + 1) * STEP);
    return r;
  endfunction

  // Quarter shape seen by a rail whose own quarter index is qtr.
  function automatic logic [DAC_W-1:0] shape_code(input logic [1:0] qtr,
                                                  input logic [QW-1:0] qv);
    logic [DAC_W-1:0] r;
    case (qtr)
      2'd0:    r = ramp_code(qv);
      2'd1:    r = MAX;
      2'd2:    r = MAX - ramp_code(qv);
      default: r = '0;
    endcase
    return r;
  endfunction

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ph_q    <= '0;
      q_q     <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      q_q     <= q_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      stop_q  <= stop_d;
    end
  end

  // Next-state logic: quarter/cycle stepping, period counting, burst end.
  always_comb begin
    state_d  = state_q;
    ph_d     = ph_q;
    q_d      = q_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    stop_d   = stop_q;
    stop_now = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_RUN;
          len_d   = bus.burst_len;
          cnt_d   = '0;
          stop_d  = 1'b0;
          ph_d    = 2'd0;
          q_d     = '0;
        end
      end
      S_RUN: begin
        // A stop on the boundary cycle itself still ends this period.
        stop_now = stop_q | bus.stop;
        stop_d   = stop_now;
        if (q_q == Q_LAST) begin
          q_d  = '0;
          ph_d = ph_q + 2'd1;
          if (ph_q == 2'd3) begin
            cnt_d = cnt_q + 1'b1;
            if (((len_q != '0) && (cnt_d == len_q)) || stop_now) begin
              state_d = S_DRAIN;
            end
          end
        end else begin
          q_d = q_q + 1'b1;
        end
      end
      S_DRAIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state so every output is a flop.
  always_comb begin
    busy_d   = (state_d == S_RUN);
    done_d   = (state_d == S_DRAIN);
    strobe_d = busy_d && (ph_d == 2'd2) && (q_d == Q_MID);
    pos1_d   = '0;
    pos2_d   = '0;
    if (busy_d) begin
      pos1_d = shape_code(ph_d, q_d);
      pos2_d = shape_code(ph_d - 2'd1, q_d);
    end
    neg1_d = MAX - pos1_d;
    neg2_d = MAX - pos2_d;
  end

  // Registered rail codes and status; reset snaps rails to idle levels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos1_q   <= '0;
      neg1_q   <= MAX;
      pos2_q   <= '0;
      neg2_q   <= MAX;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      pos1_q   <= pos1_d;
      neg1_q   <= neg1_d;
      pos2_q   <= pos2_d;
      neg2_q   <= neg2_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      strobe_q <= strobe_d;
    end
  end

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.sample_strobe = strobe_q;
  assign bus.clkpos1_code  = pos1_q;
  assign bus.clkneg1_code  = neg1_q;
  assign bus.clkpos2_code  = pos2_q;
  assign bus.clkneg2_code  = neg2_q;
  assign bus.period_count  = cnt_q;
  assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_adiabatic_pclk_gen.sv
// Bench for the adiabatic power-clock sequencer: directed scenarios plus
// randomized bursts checked cycle-by-cycle against a trapezoid model.
module tb_adiabatic_pclk_gen;

  localparam int Q   = 4;
  localparam int DW  = 6;
  localparam int CW  = 16;
  localparam int MX  = (1 << DW) - 1;
  localparam int PER = 4 * Q;
  localparam int EW  = 3 + 4 * DW + CW;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;

  logic [EW-1:0] exp_q[$];
  int            hist_p1[$];
  int            busy_cnt, strobe_cnt, done_cnt;

  adiabatic_pclk_gen_if #(.DAC_W(DW), .CNT_W(CW)) bus ();

  adiabatic_pclk_gen #(.QTR_CYCLES(Q), .DAC_W(DW), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference trapezoid: phase-1 rail at cycle t of a period.
  function automatic int pos1_at(input int t);
    int qt, qq, ramp;
    qt   = t / Q;
    qq   = t % Q;
    ramp = (qq == Q - 1) ? MX : (qq + 1) * (MX / Q);
    case (qt)
      0:       return ramp;
      1:       return MX;
      2:       return MX - ramp;
      default: return 0;
    endcase
  endfunction

  function automatic logic [EW-1:0] pack(input bit b, input bit d, input bit s,
                                         input int p1, input int p2, input int cnt);
    logic [DW-1:0] a1, a2, n1, n2;
    logic [CW-1:0] c;
    a1 = DW'(p1); n1 = DW'(MX - p1);
    a2 = DW'(p2); n2 = DW'(MX - p2);
    c  = CW'(cnt);
    return {b, d, s, a1, n1, a2, n2, c};
  endfunction

  function automatic logic [EW-1:0] observed();
    return {bus.busy, bus.done, bus.sample_strobe, bus.clkpos1_code, bus.clkneg1_code,
            bus.clkpos2_code, bus.clkneg2_code, bus.period_count};
  endfunction

  // Driver: one burst from IDLE, checked every cycle through DRAIN and one idle cycle.
  task automatic run_burst(input int len, input int stop_at, input int stray_at,
                           input bit stop_with_start);
    int n, total;
    logic [EW-1:0] e;
    if (stop_at >= 0) n = stop_at / PER + 1;
    else              n = len;
    if (len != 0 && n > len) n = len;
    total = n * PER;
    exp_q.delete();
    for (int p = 0; p < n; p++)
      for (int t = 0; t < PER; t++)
        exp_q.push_back(pack(1'b1, 1'b0, (t == 2 * Q + Q / 2), pos1_at(t),
                             pos1_at((t + PER - Q) % PER), p));
    exp_q.push_back(pack(1'b0, 1'b1, 1'b0, 0, 0, n));
    exp_q.push_back(pack(1'b0, 1'b0, 1'b0, 0, 0, n));
    hist_p1.delete();
    busy_cnt = 0; strobe_cnt = 0; done_cnt = 0;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.burst_len = CW'(len);
    bus.stop      = stop_with_start;
    for (int c = 0; exp_q.size() > 0; c++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      check($sformatf("burst len=%0d cyc=%0d", len, c), 64'(observed()), 64'(e));
      hist_p1.push_back(int'(bus.clkpos1_code));
      busy_cnt   += int'(bus.busy);
      strobe_cnt += int'(bus.sample_strobe);
      done_cnt   += int'(bus.done);
      bus.start     = (c == stray_at) && (c < total);
      bus.burst_len = (stray_at >= 0 && c >= stray_at) ? CW'(7) : CW'(len);
      bus.stop      = (c == stop_at);
    end
    bus.start = 1'b0;
    bus.stop  = 1'b0;
  endtask

  int tp1[16] = '{15, 30, 45, 63, 63, 63, 63, 63, 48, 33, 18, 0, 0, 0, 0, 0};

  initial begin
    int len, stop_at, stray;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.burst_len = '0;
    bus.stop      = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'(observed()), 64'(pack(0, 0, 0, 0, 0, 0)));
    check("reset_state", 64'(dbg_state), 64'd0);
    rst_n = 1'b1;

    // Idle with start low
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("idle cyc=%0d", i), 64'(observed()), 64'(pack(0, 0, 0, 0, 0, 0)));
    end

    // Single period with explicit phase-1 code table
    run_burst(1, -1, -1, 1'b0);
    for (int i = 0; i < 16; i++)
      check($sformatf("p1_table idx=%0d", i), 64'(hist_p1[i]), 64'(tp1[i]));
    check("len1_done_count", 64'(done_cnt), 64'd1);

    // Three periods: busy length and strobe count
    run_burst(3, -1, -1, 1'b0);
    check("len3_busy_cycles", 64'(busy_cnt), 64'd48);
    check("len3_strobes", 64'(strobe_cnt), 64'd3);
    check("len3_done_count", 64'(done_cnt), 64'd1);
    check("len3_period_count", 64'(bus.period_count), 64'd3);

    // Continuous run, stop at ph1 of the 5th period
    run_burst(0, 4 * PER + Q + 1, -1, 1'b0);
    check("cont_period_count", 64'(bus.period_count), 64'd5);
    check("cont_done_count", 64'(done_cnt), 64'd1);

    // Stop exactly on a period boundary cycle ends that period
    run_burst(0, 2 * PER - 1, -1, 1'b0);
    check("bnd_period_count", 64'(bus.period_count), 64'd2);

    // Stray start and burst_len change mid-burst
    run_burst(2, -1, 5, 1'b0);
    check("stray_done_count", 64'(done_cnt), 64'd1);

    // Simultaneous start and stop in IDLE: stop not sampled
    run_burst(2, -1, -1, 1'b1);
    check("startstop_period_count", 64'(bus.period_count), 64'd2);

    // Asynchronous reset mid-ramp at ph1 q=2
    @(negedge clk);
    bus.start = 1'b1;
    bus.burst_len = CW'(3);
    for (int c = 0; c <= Q + 2; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    check("pre_reset_pos1", 64'(bus.clkpos1_code), 64'(MX));
    #2 rst_n = 1'b0;
    #1;
    check("async_pos1", 64'(bus.clkpos1_code), 64'd0);
    check("async_neg1", 64'(bus.clkneg1_code), 64'(MX));
    check("async_pos2", 64'(bus.clkpos2_code), 64'd0);
    check("async_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_idle", 64'(observed()), 64'(pack(0, 0, 0, 0, 0, 0)));
    check("post_reset_state", 64'(dbg_state), 64'd0);
    run_burst(1, -1, -1, 1'b0);

    // Randomized bursts
    for (int it = 0; it < 10; it++) begin
      len = $urandom_range(0, 3);
      if (len == 0) stop_at = $urandom_range(0, 3 * PER - 1);
      else          stop_at = ($urandom_range(0, 1) == 1) ? $urandom_range(0, len * PER - 1) : -1;
      stray = ($urandom_range(0, 1) == 1) ? $urandom_range(0, PER - 1) : -1;
      run_burst(len, stop_at, stray, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        check("rand_gap_idle", 64'(bus.busy), 64'd0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Rail complement invariant on every cycle
  always @(negedge clk) begin
    if (rst_n) begin
      check("inv_rail1", 64'(int'(bus.clkpos1_code) + int'(bus.clkneg1_code)), 64'(MX));
      check("inv_rail2", 64'(int'(bus.clkpos2_code) + int'(bus.clkneg2_code)), 64'(MX));
    end
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
